// File: rtl/biquad_coeff_loader_if.sv
// rtl/biquad_coeff_loader_if.sv - Wishbone classic write bus between coefficient loader and filter target
interface biquad_coeff_loader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface

// File: rtl/biquad_coeff_loader.sv
// rtl/biquad_coeff_loader.sv - staged biquad coefficient burst writer with post-load filter reset pulse
module biquad_coeff_loader #(
    parameter int DEPTH       = 32,
    parameter int ADDR_STRIDE = 4,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 3,
    parameter int RST_CYCLES  = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     buf_we_i,
    input  logic [$clog2(DEPTH)-1:0] buf_addr_i,
    input  logic [31:0]              buf_dat_i,
    input  logic                     start_i,
    input  logic [21:0]              base_adr_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2:0]               status_o,
    output logic                     reset_BQ_o,
    biquad_coeff_loader_if.master    wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int PW = $clog2(RST_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C    = DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RSTPULSE, FINISH} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [21:0]   base;
    logic [AW:0]   count;
    logic [AW:0]   idx;
    logic [TW-1:0] tmo;
    logic [RW-1:0] retry;
    logic [PW-1:0] pulse;
    logic [21:0]   stride_off;
    logic          resp;

    wire unused_rd_dat = ^wb.wb_dat_i;

    // Address arithmetic wraps modulo the 22-bit target space.
    assign stride_off = 22'(ADDR_STRIDE * idx);
    assign resp       = wb.wb_err_i | wb.wb_rty_i | wb.wb_ack_i | (tmo == TMO_LAST);

    // Staging buffer is frozen while a load is in flight so the burst is atomic.
    always_ff @(posedge wb_clk_i) begin
        if (buf_we_i && !busy_o)
            mem[buf_addr_i] <= buf_dat_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            base        <= '0;
            count       <= '0;
            idx         <= '0;
            tmo         <= '0;
            retry       <= '0;
            pulse       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            status_o    <= 3'd0;
            reset_BQ_o  <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= 4'h0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        base  <= base_adr_i;
                        count <= count_i;
                        idx   <= '0;
                        retry <= '0;
                        if (count_i == '0) begin
                            state    <= FINISH;
                            done_o   <= 1'b1;
                            status_o <= 3'd0;
                        end else if (count_i > DEPTH_C) begin
                            state    <= FINISH;
                            done_o   <= 1'b1;
                            status_o <= 3'd4;
                        end else begin
                            state  <= FETCH;
                            busy_o <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    wb.wb_dat_o <= mem[idx[AW-1:0]];
                    wb.wb_adr_o <= base + stride_off;
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= 1'b1;
                    wb.wb_sel_o <= 4'hF;
                    tmo         <= '0;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    tmo <= tmo + 1'b1;
                    if (resp) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_sel_o <= 4'h0;
                    end
                    // Same-cycle responses resolve as err over rty over ack.
                    if (wb.wb_err_i) begin
                        state    <= FINISH;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        status_o <= 3'd1;
                    end else if (wb.wb_rty_i) begin
                        if (retry == RETRY_MAX) begin
                            state    <= FINISH;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            status_o <= 3'd3;
                        end else begin
                            retry <= retry + 1'b1;
                            state <= FETCH;
                        end
                    end else if (wb.wb_ack_i) begin
                        retry <= '0;
                        idx   <= idx + 1'b1;
                        if (idx + 1'b1 == count) begin
                            state      <= RSTPULSE;
                            reset_BQ_o <= 1'b1;
                            pulse      <= '0;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (tmo == TMO_LAST) begin
                        state    <= FINISH;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        status_o <= 3'd2;
                    end
                end
                RSTPULSE: begin
                    if (pulse == PULSE_LAST) begin
                        reset_BQ_o <= 1'b0;
                        state      <= FINISH;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        status_o   <= 3'd0;
                    end else begin
                        pulse <= pulse + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb/tb_biquad_coeff_loader.sv - directed bench for the biquad coefficient loader
module tb_biquad_coeff_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        buf_we_i = 1'b0;
    logic [4:0]  buf_addr_i = '0;
    logic [31:0] buf_dat_i = '0;
    logic        start_i = 1'b0;
    logic [21:0] base_adr_i = '0;
    logic [5:0]  count_i = '0;
    logic        busy_o, done_o, reset_BQ_o;
    logic [2:0]  status_o;

    biquad_coeff_loader_if bus ();

    biquad_coeff_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .buf_we_i   (buf_we_i),
        .buf_addr_i (buf_addr_i),
        .buf_dat_i  (buf_dat_i),
        .start_i    (start_i),
        .base_adr_i (base_adr_i),
        .count_i    (count_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .status_o   (status_o),
        .reset_BQ_o (reset_BQ_o),
        .wb         (bus)
    );

    always #5 clk = ~clk;

    // Target model configuration, written only by the stimulus block
    int t_base = 0;
    int t_wait_word = 99;
    int t_wait = 0;
    int t_err_word = 99;
    int rty_cfg = 0;
    logic t_silent = 1'b0;
    int wcnt = 0;
    int rty_used = 0;

    assign bus.wb_dat_i = '0;

    always_comb begin
        int w;
        w = (int'(bus.wb_adr_o) - t_base) / 4;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        if (bus.wb_stb_o && !t_silent) begin
            if (w == t_err_word) begin
                bus.wb_err_i = 1'b1;
                bus.wb_ack_i = 1'b1;
            end else if (rty_used < rty_cfg) begin
                bus.wb_rty_i = 1'b1;
            end else if (wcnt >= ((w == t_wait_word) ? t_wait : 0)) begin
                bus.wb_ack_i = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (start_i) begin
            wcnt     <= 0;
            rty_used <= 0;
        end else if (bus.wb_stb_o) begin
            if (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i) wcnt <= 0;
            else wcnt <= wcnt + 1;
            if (bus.wb_rty_i && !bus.wb_err_i) rty_used <= rty_used + 1;
        end
    end

    // Bus monitor, sampled mid-cycle
    logic [21:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic [21:0] iss_adr[$];
    logic [31:0] iss_dat[$];
    int stb_cycles = 0, rstq_cycles = 0, done_cnt = 0, unstable = 0;
    logic stb_prev = 1'b0;
    logic [21:0] hold_adr = '0;
    logic [31:0] hold_dat = '0;

    always @(negedge clk) begin
        if (bus.wb_stb_o) begin
            stb_cycles++;
            if (!stb_prev) begin
                hold_adr = bus.wb_adr_o;
                hold_dat = bus.wb_dat_o;
                iss_adr.push_back(bus.wb_adr_o);
                iss_dat.push_back(bus.wb_dat_o);
            end else if (bus.wb_adr_o !== hold_adr || bus.wb_dat_o !== hold_dat) begin
                unstable++;
            end
            if (bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i) begin
                wr_adr.push_back(bus.wb_adr_o);
                wr_dat.push_back(bus.wb_dat_o);
            end
        end
        stb_prev = bus.wb_stb_o;
        if (reset_BQ_o) rstq_cycles++;
        if (done_o) done_cnt++;
    end

    int vectors = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        buf_we_i = 1'b1;
        buf_addr_i = a;
        buf_dat_i = d;
        @(posedge clk);
        #1 buf_we_i = 1'b0;
    endtask

    task automatic do_start(input logic [21:0] b, input logic [5:0] c);
        @(negedge clk);
        base_adr_i = b;
        count_i = c;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Returns the cycle (start edge = 1) on which done_o was seen, then lets FSM reach IDLE
    task automatic wait_done(input string tag, output int n);
        n = 1;
        while (!done_o && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_o) check({tag, "_done_timeout"}, 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    int n, s_wr, s_iss, s_stb, s_rst, s_unst, d0, diffs;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_status", status_o, 3'd0);
        check("rst_resetbq", reset_BQ_o, 1'b0);
        check("rst_cyc", bus.wb_cyc_o, 1'b0);
        check("rst_stb", bus.wb_stb_o, 1'b0);

        load_word(5'd0, 32'h1111_AAAA);
        load_word(5'd1, 32'h2222_BBBB);
        load_word(5'd2, 32'h3333_CCCC);

        // Three words, zero-wait acks
        t_base = 'h100;
        s_wr = wr_adr.size(); s_iss = iss_adr.size(); s_stb = stb_cycles; s_rst = rstq_cycles;
        do_start(22'h100, 6'd3);
        check("t1_busy", busy_o, 1'b1);
        wait_done("t1", n);
        check("t1_done_cycle", n, 11);
        check("t1_status", status_o, 3'd0);
        check("t1_done_pulse", done_o, 1'b0);
        check("t1_nwrites", wr_adr.size() - s_wr, 3);
        check("t1_adr0", wr_adr[s_wr], 22'h100);
        check("t1_dat0", wr_dat[s_wr], 32'h1111_AAAA);
        check("t1_adr1", wr_adr[s_wr+1], 22'h104);
        check("t1_dat1", wr_dat[s_wr+1], 32'h2222_BBBB);
        check("t1_adr2", wr_adr[s_wr+2], 22'h108);
        check("t1_dat2", wr_dat[s_wr+2], 32'h3333_CCCC);
        check("t1_issues", iss_adr.size() - s_iss, 3);
        check("t1_stb_cycles", stb_cycles - s_stb, 3);
        check("t1_resetbq_cycles", rstq_cycles - s_rst, 4);

        // Five wait states on word 1
        t_wait_word = 1; t_wait = 5;
        s_stb = stb_cycles; s_unst = unstable; s_wr = wr_adr.size();
        do_start(22'h100, 6'd3);
        wait_done("t2", n);
        check("t2_done_cycle", n, 16);
        check("t2_stb_cycles", stb_cycles - s_stb, 8);
        check("t2_stable", unstable - s_unst, 0);
        check("t2_status", status_o, 3'd0);
        check("t2_adr1", wr_adr[s_wr+1], 22'h104);
        t_wait_word = 99; t_wait = 0;

        // Silent target times out
        t_silent = 1'b1;
        s_stb = stb_cycles; s_rst = rstq_cycles;
        do_start(22'h100, 6'd1);
        wait_done("t3", n);
        check("t3_stb_cycles", stb_cycles - s_stb, 255);
        check("t3_status", status_o, 3'd2);
        check("t3_no_resetbq", rstq_cycles - s_rst, 0);
        t_silent = 1'b0;

        // Four retries exhaust the budget
        t_base = 'h300; rty_cfg = 4;
        s_iss = iss_adr.size(); s_rst = rstq_cycles; s_wr = wr_adr.size();
        do_start(22'h300, 6'd1);
        wait_done("t4", n);
        check("t4_issues", iss_adr.size() - s_iss, 4);
        diffs = 0;
        for (int i = s_iss; i < iss_adr.size(); i++)
            if (iss_adr[i] !== 22'h300 || iss_dat[i] !== 32'h1111_AAAA) diffs++;
        check("t4_same_word", diffs, 0);
        check("t4_status", status_o, 3'd3);
        check("t4_no_resetbq", rstq_cycles - s_rst, 0);
        check("t4_no_write", wr_adr.size() - s_wr, 0);

        // Two retries then ack
        rty_cfg = 2;
        s_iss = iss_adr.size(); s_wr = wr_adr.size();
        do_start(22'h300, 6'd1);
        wait_done("t5", n);
        check("t5_issues", iss_adr.size() - s_iss, 3);
        check("t5_status", status_o, 3'd0);
        check("t5_adr", wr_adr[s_wr], 22'h300);
        rty_cfg = 0;

        // err together with ack on word 1
        t_base = 'h100; t_err_word = 1;
        s_wr = wr_adr.size(); s_rst = rstq_cycles;
        do_start(22'h100, 6'd3);
        wait_done("t6", n);
        check("t6_status", status_o, 3'd1);
        check("t6_nwrites", wr_adr.size() - s_wr, 1);
        check("t6_no_resetbq", rstq_cycles - s_rst, 0);
        t_err_word = 99;

        // count = 0 and count = 33
        s_iss = iss_adr.size();
        do_start(22'h100, 6'd0);
        check("t7_done_next", done_o, 1'b1);
        wait_done("t7", n);
        check("t7_status", status_o, 3'd0);
        do_start(22'h100, 6'd33);
        check("t8_done_next", done_o, 1'b1);
        wait_done("t8", n);
        check("t8_status", status_o, 3'd4);
        check("t78_no_cyc", iss_adr.size() - s_iss, 0);

        // Async reset during ISSUE; buffer write while busy must be dropped
        t_silent = 1'b1;
        do_start(22'h100, 6'd3);
        n = 0;
        while (!bus.wb_stb_o && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t9_in_issue", bus.wb_stb_o, 1'b1);
        load_word(5'd0, 32'hDEAD_BEEF);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("t9_cyc_drop", bus.wb_cyc_o, 1'b0);
        check("t9_stb_drop", bus.wb_stb_o, 1'b0);
        check("t9_busy_drop", busy_o, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t9_no_done", done_cnt - d0, 0);
        check("t9_status_cleared", status_o, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        t_silent = 1'b0;
        t_base = 'h200;
        s_wr = wr_adr.size();
        do_start(22'h200, 6'd1);
        wait_done("t9", n);
        check("t9_reload_adr", wr_adr[s_wr], 22'h200);
        check("t9_reload_dat", wr_dat[s_wr], 32'h1111_AAAA);
        check("t9_status", status_o, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
